// File: rtl/mmu_pkg.sv
// Shared types for the address-translation sequencer: exception classes, segment
// constants, FSM states, TLB lookup result and the micro-TLB entry layout.
package mmu_pkg;

   typedef logic [31:0] virt_t;

   // Combinational result returned by the TLB lookup stage.
   typedef struct packed {
      logic        miss;
      logic        valid;
      logic        dirty;
      logic        global_flag;
      logic [2:0]  cache_flag;
      logic [31:0] phy_addr;
   } tlb_result_t;

   typedef enum logic [1:0] {
      EXC_NONE    = 2'd0,
      EXC_REFILL  = 2'd1,
      EXC_INVALID = 2'd2,
      EXC_MOD     = 2'd3
   } mmu_exc_t;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLookup = 2'd1,
      StResp   = 2'd2
   } mmu_state_t;

   localparam logic [2:0] KSEG0 = 3'b100;
   localparam logic [2:0] KSEG1 = 3'b101;

   typedef struct packed {
      logic        valid;
      logic [19:0] vpn;
      logic [7:0]  asid;
      logic        global_flag;
      logic [19:0] pfn;
      logic        dirty;
      logic        uncached;
   } utlb_entry_t;

   function automatic logic is_unmapped(input virt_t va);
      return (va[31:29] == KSEG0) || (va[31:29] == KSEG1);
   endfunction

endpackage

// File: rtl/mmu_utlb.sv
// Single-entry micro-TLB: holds the last successful translation and reports a hit
// for a matching page. Flush takes priority over a fill in the same cycle.
module mmu_utlb
   import mmu_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_flush,
   input  logic        i_fill,
   input  logic [19:0] i_fill_vpn,
   input  logic [7:0]  i_fill_asid,
   input  logic        i_fill_global,
   input  logic [19:0] i_fill_pfn,
   input  logic        i_fill_dirty,
   input  logic        i_fill_uncached,
   input  logic [19:0] i_vpn,
   input  logic [7:0]  i_asid,
   input  logic        i_is_store,
   output logic        o_hit,
   output logic [19:0] o_pfn,
   output logic        o_uncached
);

   utlb_entry_t r_entry;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_entry <= '0;
      end else if (i_flush) begin
         r_entry.valid <= 1'b0;
      end else if (i_fill) begin
         r_entry.valid       <= 1'b1;
         r_entry.vpn         <= i_fill_vpn;
         r_entry.asid        <= i_fill_asid;
         r_entry.global_flag <= i_fill_global;
         r_entry.pfn         <= i_fill_pfn;
         r_entry.dirty       <= i_fill_dirty;
         r_entry.uncached    <= i_fill_uncached;
      end
   end

   // A store to a clean page must go to the TLB so the Modified exception is raised.
   assign o_hit = r_entry.valid
               && (r_entry.vpn == i_vpn)
               && ((r_entry.asid == i_asid) || r_entry.global_flag)
               && (!i_is_store || r_entry.dirty);

   assign o_pfn      = r_entry.pfn;
   assign o_uncached = r_entry.uncached;

endmodule

// File: rtl/mmu_translate.sv
// Address-translation sequencer: resolves kseg0/kseg1 directly, walks mapped addresses
// through the TLB lookup port. Optional one-entry micro-TLB under `define MMU_UTLB_EN.
module mmu_translate
   import mmu_pkg::*;
#(
   parameter logic [2:0] KSEG0_UNCACHED_K0 = 3'd2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [31:0] i_req_vaddr,
   input  logic        i_req_is_store,
   input  logic [7:0]  i_cp0_asid,
   input  logic [2:0]  i_cp0_k0,
   input  logic        i_tlb_flush,
   output logic [31:0] o_lookup_vaddr,
   output logic [7:0]  o_lookup_asid,
   input  tlb_result_t i_lookup_result,
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [31:0] o_resp_paddr,
   output logic        o_resp_uncached,
   output mmu_exc_t    o_resp_exc,
   output logic [31:0] o_resp_badvaddr
);

   mmu_state_t  r_state, w_state_next;
   virt_t       r_s1_vaddr;
   logic        r_s1_is_store;

   logic [31:0] r_resp_paddr, w_resp_paddr;
   logic        r_resp_uncached, w_resp_uncached;
   mmu_exc_t    r_resp_exc, w_resp_exc;
   logic [31:0] r_resp_badvaddr, w_resp_badvaddr;

   logic        w_fire;
   logic        w_req_unmapped;
   mmu_exc_t    w_lookup_exc;
   logic        w_lookup_uncached;
   logic        w_utlb_fill;
   logic        w_utlb_hit;
   logic [19:0] w_utlb_pfn;
   logic        w_utlb_uncached;

   assign w_fire         = i_req_valid && (r_state == StIdle);
   assign w_req_unmapped = is_unmapped(i_req_vaddr);

   assign o_req_ready    = (r_state == StIdle);
   assign o_resp_valid   = (r_state == StResp);
   assign o_lookup_vaddr = r_s1_vaddr;
   assign o_lookup_asid  = i_cp0_asid;

   assign o_resp_paddr    = r_resp_paddr;
   assign o_resp_uncached = r_resp_uncached;
   assign o_resp_exc      = r_resp_exc;
   assign o_resp_badvaddr = r_resp_badvaddr;

   assign w_lookup_uncached = (i_lookup_result.cache_flag == KSEG0_UNCACHED_K0);

   always_comb begin
      w_lookup_exc = EXC_NONE;
      if (i_lookup_result.miss) begin
         w_lookup_exc = EXC_REFILL;
      end else if (!i_lookup_result.valid) begin
         w_lookup_exc = EXC_INVALID;
      end else if (r_s1_is_store && !i_lookup_result.dirty) begin
         w_lookup_exc = EXC_MOD;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_resp_paddr    = r_resp_paddr;
      w_resp_uncached = r_resp_uncached;
      w_resp_exc      = r_resp_exc;
      w_resp_badvaddr = r_resp_badvaddr;
      w_utlb_fill     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_req_valid) begin
               if (w_req_unmapped) begin
                  w_resp_paddr    = {3'b000, i_req_vaddr[28:0]};
                  w_resp_uncached = (i_req_vaddr[31:29] == KSEG1)
                                 || (i_cp0_k0 == KSEG0_UNCACHED_K0);
                  w_resp_exc      = EXC_NONE;
                  w_resp_badvaddr = i_req_vaddr;
                  w_state_next    = StResp;
               end else if (w_utlb_hit) begin
                  w_resp_paddr    = {w_utlb_pfn, i_req_vaddr[11:0]};
                  w_resp_uncached = w_utlb_uncached;
                  w_resp_exc      = EXC_NONE;
                  w_resp_badvaddr = i_req_vaddr;
                  w_state_next    = StResp;
               end else begin
                  w_state_next = StLookup;
               end
            end
         end
         StLookup: begin
            w_resp_paddr    = i_lookup_result.phy_addr;
            w_resp_uncached = w_lookup_uncached;
            w_resp_exc      = w_lookup_exc;
            w_resp_badvaddr = r_s1_vaddr;
            w_utlb_fill     = (w_lookup_exc == EXC_NONE);
            w_state_next    = StResp;
         end
         StResp: begin
            if (i_resp_ready) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= StIdle;
         r_s1_vaddr      <= '0;
         r_s1_is_store   <= 1'b0;
         r_resp_paddr    <= '0;
         r_resp_uncached <= 1'b0;
         r_resp_exc      <= EXC_NONE;
         r_resp_badvaddr <= '0;
      end else begin
         r_state         <= w_state_next;
         r_resp_paddr    <= w_resp_paddr;
         r_resp_uncached <= w_resp_uncached;
         r_resp_exc      <= w_resp_exc;
         r_resp_badvaddr <= w_resp_badvaddr;
         if (w_fire) begin
            r_s1_vaddr    <= i_req_vaddr;
            r_s1_is_store <= i_req_is_store;
         end
      end
   end

`ifdef MMU_UTLB_EN
   mmu_utlb u_utlb (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_flush         (i_tlb_flush),
      .i_fill          (w_utlb_fill),
      .i_fill_vpn      (r_s1_vaddr[31:12]),
      .i_fill_asid     (i_cp0_asid),
      .i_fill_global   (i_lookup_result.global_flag),
      .i_fill_pfn      (i_lookup_result.phy_addr[31:12]),
      .i_fill_dirty    (i_lookup_result.dirty),
      .i_fill_uncached (w_lookup_uncached),
      .i_vpn           (i_req_vaddr[31:12]),
      .i_asid          (i_cp0_asid),
      .i_is_store      (i_req_is_store),
      .o_hit           (w_utlb_hit),
      .o_pfn           (w_utlb_pfn),
      .o_uncached      (w_utlb_uncached)
   );
`else
   assign w_utlb_hit      = 1'b0;
   assign w_utlb_pfn      = '0;
   assign w_utlb_uncached = 1'b0;

   // Inputs that only feed the micro-TLB.
   logic w_unused_utlb;
   assign w_unused_utlb = ^{i_tlb_flush, w_utlb_fill, i_lookup_result.global_flag};
`endif

endmodule

// File: tb/tb_mmu_translate.sv
// Self-checking bench for mmu_translate; expected responses queue up as each request
// is driven and are popped when the response appears. Honours `define MMU_UTLB_EN.
module tb_mmu_translate;
   import mmu_pkg::*;

`ifdef MMU_UTLB_EN
   localparam bit UTLB = 1'b1;
`else
   localparam bit UTLB = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] paddr;
      logic        uncached;
      mmu_exc_t    exc;
      logic [31:0] badvaddr;
      logic [3:0]  lat;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_is_store;
   logic [31:0] req_vaddr;
   logic [7:0]  cp0_asid;
   logic [2:0]  cp0_k0;
   logic        tlb_flush;
   logic [31:0] lookup_vaddr;
   logic [7:0]  lookup_asid;
   tlb_result_t tb_tlb;
   logic        resp_valid, resp_ready, resp_uncached;
   logic [31:0] resp_paddr, resp_badvaddr;
   mmu_exc_t    resp_exc;

   resp_t sb_q[$];
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   mmu_translate #(.KSEG0_UNCACHED_K0(3'd2)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_req_valid     (req_valid),
      .o_req_ready     (req_ready),
      .i_req_vaddr     (req_vaddr),
      .i_req_is_store  (req_is_store),
      .i_cp0_asid      (cp0_asid),
      .i_cp0_k0        (cp0_k0),
      .i_tlb_flush     (tlb_flush),
      .o_lookup_vaddr  (lookup_vaddr),
      .o_lookup_asid   (lookup_asid),
      .i_lookup_result (tb_tlb),
      .o_resp_valid    (resp_valid),
      .i_resp_ready    (resp_ready),
      .o_resp_paddr    (resp_paddr),
      .o_resp_uncached (resp_uncached),
      .o_resp_exc      (resp_exc),
      .o_resp_badvaddr (resp_badvaddr)
   );

   function automatic resp_t mk(input logic [31:0] pa, input logic unc, input mmu_exc_t exc,
                                input logic [31:0] bad, input int lat);
      resp_t r;
      r.paddr = pa; r.uncached = unc; r.exc = exc; r.badvaddr = bad; r.lat = 4'(lat);
      return r;
   endfunction

   function automatic string fmt(input resp_t r);
      return $sformatf("paddr=%h unc=%b exc=%0d bad=%h lat=%0d",
                       r.paddr, r.uncached, r.exc, r.badvaddr, r.lat);
   endfunction

   function automatic tlb_result_t mk_tlb(input logic miss, input logic v, input logic d,
                                          input logic g, input logic [2:0] c,
                                          input logic [31:0] pa);
      tlb_result_t t;
      t.miss = miss; t.valid = v; t.dirty = d; t.global_flag = g; t.cache_flag = c;
      t.phy_addr = pa;
      return t;
   endfunction

   // Drives one request, pushes its expectation, waits (bounded) for the response.
   task automatic issue(input logic [31:0] va, input logic st, input resp_t exp,
                        input logic flush_on_fill, output resp_t got, output resp_t want);
      sb_q.push_back(exp);
      @(negedge clk);
      req_valid = 1'b1; req_vaddr = va; req_is_store = st;
      @(posedge clk); #1;
      req_valid = 1'b0;
      got.lat = 4'd1;
      if (!resp_valid) begin
         checks++;
         if (lookup_vaddr !== va || lookup_asid !== cp0_asid) begin
            errors++;
            $display("FAIL lookup_port: got %h/%h want %h/%h", lookup_vaddr, lookup_asid,
                     va, cp0_asid);
         end
         if (flush_on_fill) tlb_flush = 1'b1;
      end
      while (!resp_valid && got.lat < 4'd10) begin
         @(posedge clk); #1;
         tlb_flush = 1'b0;
         got.lat = got.lat + 4'd1;
      end
      got.paddr = resp_paddr; got.uncached = resp_uncached;
      got.exc = resp_exc; got.badvaddr = resp_badvaddr;
      want = sb_q.pop_front();
   endtask

   task automatic release_resp();
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic pulse_flush();
      @(negedge clk);
      tlb_flush = 1'b1;
      @(posedge clk); #1;
      tlb_flush = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
      checks++;
      if ({resp_paddr, resp_uncached, resp_badvaddr} !== 65'd0) begin
         errors++;
         $display("FAIL reset_resp_regs: got %h %b %h want zeros", resp_paddr, resp_uncached, resp_badvaddr);
      end
      checks++;
      if (resp_exc !== EXC_NONE) begin errors++; $display("FAIL reset_exc: got %0d want 0", resp_exc); end
   endtask

   task automatic test_unmapped();
      resp_t got, want;
      cp0_k0 = 3'd3;
      issue(32'h8000_1234, 1'b0, mk(32'h0000_1234, 1'b0, EXC_NONE, 32'h8000_1234, 1), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL kseg0_cached: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
      issue(32'hA000_0040, 1'b1, mk(32'h0000_0040, 1'b1, EXC_NONE, 32'hA000_0040, 1), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL kseg1: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
      cp0_k0 = 3'd2;
      issue(32'h9FFF_FFFC, 1'b0, mk(32'h1FFF_FFFC, 1'b1, EXC_NONE, 32'h9FFF_FFFC, 1), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL kseg0_uncached: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
      cp0_k0 = 3'd3;
   endtask

   task automatic test_exceptions();
      resp_t got, want;
      tb_tlb = mk_tlb(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 32'h0000_0000);
      issue(32'h0040_0000, 1'b0, mk(32'h0, 1'b0, EXC_REFILL, 32'h0040_0000, 2), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL refill: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
      tb_tlb = mk_tlb(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 32'h0ABC_D010);
      issue(32'h0040_0010, 1'b0, mk(32'h0ABC_D010, 1'b1, EXC_INVALID, 32'h0040_0010, 2), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL invalid: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
      tb_tlb = mk_tlb(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 32'h0ABC_D010);
      issue(32'h0040_0010, 1'b1, mk(32'h0ABC_D010, 1'b0, EXC_MOD, 32'h0040_0010, 2), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL modified: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
      issue(32'h0040_0010, 1'b0, mk(32'h0ABC_D010, 1'b0, EXC_NONE, 32'h0040_0010, 2), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL load_clean: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
      // Clean page cached: a store must still reach the TLB and fault.
      issue(32'h0040_0010, 1'b1, mk(32'h0ABC_D010, 1'b0, EXC_MOD, 32'h0040_0010, 2), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL store_clean_again: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
      issue(32'h0040_0010, 1'b0, mk(32'h0ABC_D010, 1'b0, EXC_NONE, 32'h0040_0010, UTLB ? 1 : 2), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL load_clean_again: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
   endtask

   task automatic test_hold();
      resp_t got, want;
      pulse_flush();
      tb_tlb = mk_tlb(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 32'h1234_5ABC);
      issue(32'h0040_0ABC, 1'b0, mk(32'h1234_5ABC, 1'b0, EXC_NONE, 32'h0040_0ABC, 2), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL mapped: got %s want %s", fmt(got), fmt(want)); end
      @(negedge clk);
      req_valid = 1'b1; req_vaddr = 32'h8000_0000; req_is_store = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (!resp_valid || req_ready || resp_paddr !== 32'h1234_5ABC || resp_uncached
             || resp_exc !== EXC_NONE || resp_badvaddr !== 32'h0040_0ABC) begin
            errors++;
            $display("FAIL hold_stable[%0d]: got v=%b rdy=%b pa=%h unc=%b exc=%0d bad=%h want v=1 rdy=0 pa=12345abc unc=0 exc=0 bad=00400abc",
                     i, resp_valid, req_ready, resp_paddr, resp_uncached, resp_exc, resp_badvaddr);
         end
      end
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_no_accept: got v=%b rdy=%b want v=0 rdy=1", resp_valid, req_ready);
      end
   endtask

   task automatic test_utlb();
      resp_t got, want;
      pulse_flush();
      cp0_asid = 8'h11;
      tb_tlb = mk_tlb(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 32'h1234_5AC0);
      issue(32'h0040_0AC0, 1'b0, mk(32'h1234_5AC0, 1'b0, EXC_NONE, 32'h0040_0AC0, 2), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL utlb_first: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
      // A hit must use the stored translation, not the live lookup result.
      if (UTLB) tb_tlb.phy_addr = 32'hFFFF_FAC0;
      issue(32'h0040_0AC0, 1'b0, mk(32'h1234_5AC0, 1'b0, EXC_NONE, 32'h0040_0AC0, UTLB ? 1 : 2), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL utlb_repeat: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
      tb_tlb.phy_addr = 32'h1234_5AC0;
      cp0_asid = 8'h22;
      issue(32'h0040_0AC0, 1'b0, mk(32'h1234_5AC0, 1'b0, EXC_NONE, 32'h0040_0AC0, 2), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL utlb_asid_change: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
      pulse_flush();
      tb_tlb.global_flag = 1'b1;
      issue(32'h0040_0AC0, 1'b0, mk(32'h1234_5AC0, 1'b0, EXC_NONE, 32'h0040_0AC0, 2), 1'b0, got, want);
      release_resp();
      cp0_asid = 8'h33;
      issue(32'h0040_0AC4, 1'b1, mk(32'h1234_5AC4, 1'b0, EXC_NONE, 32'h0040_0AC4, UTLB ? 1 : 2), 1'b0, got, want);
      if (!UTLB) want.paddr = 32'h1234_5AC0;
      checks++;
      if (got !== want) begin errors++; $display("FAIL utlb_global_store: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
      tb_tlb = mk_tlb(1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 32'h0077_7010);
      issue(32'h0050_0010, 1'b0, mk(32'h0077_7010, 1'b1, EXC_NONE, 32'h0050_0010, 2), 1'b1, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL flush_on_fill: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
      issue(32'h0050_0010, 1'b0, mk(32'h0077_7010, 1'b1, EXC_NONE, 32'h0050_0010, 2), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL after_flush_fill: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
      issue(32'h0050_0010, 1'b0, mk(32'h0077_7010, 1'b1, EXC_NONE, 32'h0050_0010, UTLB ? 1 : 2), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL refilled_hit: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
   endtask

   task automatic test_reset_inflight();
      resp_t got, want;
      tb_tlb = mk_tlb(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 32'h00AB_C004);
      // Mapped request, reset while in LOOKUP.
      @(negedge clk);
      req_valid = 1'b1; req_vaddr = 32'h0060_0004; req_is_store = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_exc !== EXC_NONE) begin
         errors++;
         $display("FAIL reset_in_lookup: got v=%b rdy=%b exc=%0d want 0/1/0", resp_valid, req_ready, resp_exc);
      end
      // Fill the micro-TLB, then reset while a response is pending.
      issue(32'h0060_0004, 1'b0, mk(32'h00AB_C004, 1'b0, EXC_NONE, 32'h0060_0004, 2), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL pre_reset_fill: got %s want %s", fmt(got), fmt(want)); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_exc !== EXC_NONE
          || resp_paddr !== 32'd0 || resp_badvaddr !== 32'd0) begin
         errors++;
         $display("FAIL reset_in_resp: got v=%b rdy=%b exc=%0d pa=%h bad=%h want 0/1/0/0/0",
                  resp_valid, req_ready, resp_exc, resp_paddr, resp_badvaddr);
      end
      issue(32'h0060_0004, 1'b0, mk(32'h00AB_C004, 1'b0, EXC_NONE, 32'h0060_0004, 2), 1'b0, got, want);
      checks++;
      if (got !== want) begin errors++; $display("FAIL utlb_empty_after_reset: got %s want %s", fmt(got), fmt(want)); end
      release_resp();
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_vaddr = '0; req_is_store = 1'b0;
      cp0_asid = 8'h11; cp0_k0 = 3'd3; tlb_flush = 1'b0; resp_ready = 1'b0;
      tb_tlb = '0;
      test_reset();
      test_unmapped();
      test_exceptions();
      test_hold();
      test_utlb();
      test_reset_inflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
